// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit.
//   master : drives start, aluop, functioncode, shamt, a, b
//            observes result, zero, overflow, illegal, busy, done
//   slave  : the execution unit side (directions mirrored)
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             start;
    logic [1:0]       aluop;
    logic [5:0]       functioncode;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             busy;
    logic             done;

    modport master (
        output start, aluop, functioncode, shamt, a, b,
        input  result, zero, overflow, illegal, busy, done
    );

    modport slave (
        input  start, aluop, functioncode, shamt, a, b,
        output result, zero, overflow, illegal, busy, done
    );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS-style ALU execution unit with a bit-serial shifter.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : alu_exec_unit_if.slave (request operands in, registered result out)
// Single-cycle ops complete one cycle after accept; sll/srl take one cycle per
// shifted bit in SHIFT before DONE. A start in DONE is accepted back-to-back.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_SRL, OP_ILL
    } op_e;

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic             illegal_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] shreg_q;
    logic [SHW-1:0]   cnt_q;
    logic             dir_right_q;

    op_e              op_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_ovf_c;
    logic             is_shift_c;
    logic [WIDTH-1:0] shift_nxt_c;
    logic             accept_c;

    // Decode aluop/funct into an operation.
    always_comb begin
        op_c = OP_ILL;
        case (bus.aluop)
            2'b00: op_c = OP_ADD;
            2'b01: op_c = OP_SUB;
            2'b10: begin
                case (bus.functioncode)
                    6'b000000: op_c = OP_SLL;
                    6'b000010: op_c = OP_SRL;
                    6'b100000: op_c = OP_ADD;
                    6'b100010: op_c = OP_SUB;
                    6'b100100: op_c = OP_AND;
                    6'b100101: op_c = OP_OR;
                    6'b100111: op_c = OP_NOR;
                    6'b101010: op_c = OP_SLT;
                    default:   op_c = OP_ILL;
                endcase
            end
            default: op_c = OP_ILL;
        endcase
    end

    // Single-cycle result for the incoming request; shifts with shamt=0 pass b.
    always_comb begin
        sum_c     = bus.a + bus.b;
        diff_c    = bus.a - bus.b;
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        case (op_c)
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (bus.a[MSB] == bus.b[MSB]) && (sum_c[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (bus.a[MSB] != bus.b[MSB]) && (diff_c[MSB] != bus.a[MSB]);
            end
            OP_AND:  alu_res_c = bus.a & bus.b;
            OP_OR:   alu_res_c = bus.a | bus.b;
            OP_NOR:  alu_res_c = ~(bus.a | bus.b);
            OP_SLT:  alu_res_c = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLL,
            OP_SRL:  alu_res_c = bus.b;
            default: alu_res_c = '0;
        endcase
    end

    always_comb begin
        accept_c    = bus.start && (state_q != S_SHIFT);
        is_shift_c  = ((op_c == OP_SLL) || (op_c == OP_SRL)) && (bus.shamt != '0);
        shift_nxt_c = dir_right_q ? (shreg_q >> 1) : (shreg_q << 1);
    end

    // State, shifter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_SHIFT: begin
                    shreg_q <= shift_nxt_c;
                    cnt_q   <= cnt_q - SHW'(1);
                    // Last bit shifted this cycle: publish directly.
                    if (cnt_q == SHW'(1)) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        result_q   <= shift_nxt_c;
                        zero_q     <= (shift_nxt_c == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                    end
                end
                default: begin
                    if (accept_c) begin
                        if (is_shift_c) begin
                            state_q     <= S_SHIFT;
                            busy_q      <= 1'b1;
                            shreg_q     <= bus.b;
                            cnt_q       <= bus.shamt;
                            dir_right_q <= (op_c == OP_SRL);
                        end else begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            result_q   <= alu_res_c;
                            zero_q     <= (alu_res_c == '0);
                            overflow_q <= alu_ovf_c;
                            illegal_q  <= (op_c == OP_ILL);
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
    assign bus.illegal  = illegal_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when the unit is able to accept.
REQ-006 aluop  input  2  00 add (lw/sw), 01 sub (beq), 10 R-type via functioncode, 11 reserved.
REQ-007 functioncode  input  6  R-type funct field; ignored unless aluop=10.
REQ-008 shamt  input  SHW  shift amount for sll/srl.
REQ-009 a  input  WIDTH  operand A (rs).
REQ-010 b  input  WIDTH  operand B (rt); shifted operand for sll/srl.
REQ-011 result  output  WIDTH  registered result; held until the next done.
REQ-012 zero  output  1  registered, high when result is all-zero.
REQ-013 overflow  output  1  registered signed overflow; add/sub only.
REQ-014 illegal  output  1  registered, high when the accepted request decoded to no operation.
REQ-015 busy  output  1  high while a multi-cycle shift is in progress.
REQ-016 done  output  1  one-cycle pulse; result/zero/overflow/illegal valid in that cycle.

Function
REQ-017 Decode: aluop=10 with funct 000000 sll, 000010 srl, 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt; any other funct, or aluop=11, is illegal.
REQ-018 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-019 Accept: start=1 while state is IDLE or DONE latches aluop, functioncode, shamt, a, b in that cycle.
REQ-020 start while state is SHIFT is ignored: no latch, no queueing, no effect on the current operation.
REQ-021 Non-shift or illegal op accepted in cycle N -> state DONE in cycle N+1, done=1 in N+1.
REQ-022 Shift with shamt=0 -> behaves as REQ-021, result=b.
REQ-023 Shift with shamt=k>0 accepted in cycle N -> SHIFT for cycles N+1..N+k (busy=1), one bit shifted per cycle, DONE in N+k+1.
REQ-024 sll shifts in zeros at the LSB; srl shifts in zeros at the MSB; shamt values >= WIDTH (only reachable if the SHW rule is violated) are out of scope.
REQ-025 DONE with start=0 -> IDLE next cycle; DONE with start=1 -> accepts per REQ-019 (back-to-back, one op completion per cycle).
REQ-026 add/sub wrap modulo 2^WIDTH; overflow=1 when operand signs (after negating B for sub) match and the result sign differs.
REQ-027 slt: result=1 (zero-extended) when a<b as signed two's complement, including when a-b overflows; else 0.
REQ-028 and/or/nor bitwise over full WIDTH.
REQ-029 overflow=0 for every op except add/sub.
REQ-030 Illegal op: result=0, zero=1, overflow=0, illegal=1 at done.
REQ-031 result, zero, overflow, illegal update only in the cycle done rises; they hold their values otherwise.
REQ-032 busy=1 exactly in SHIFT; done and busy are never high together.

Reset
REQ-033 reset=1 at a clock edge -> next cycle state IDLE, result=0, zero=1, overflow=0, illegal=0, busy=0, done=0.
REQ-034 Reset mid-shift aborts the operation; no done is produced for it.
REQ-035 Reset has priority over start in the same cycle; that start is dropped.

Verification (WIDTH=32)
REQ-036 aluop=00, a=7, b=5, start one cycle -> next cycle done=1, result=12, zero=0, overflow=0.
REQ-037 aluop=01, a=32'h8000_0000, b=1 -> result=32'h7FFF_FFFF, overflow=1; then aluop=10 funct 101010 same operands -> result=1, overflow=0.
REQ-038 aluop=10 funct 000000, b=32'h0000_0001, shamt=4 -> busy high 4 cycles, done on 5th cycle after start, result=32'h10; extra start during busy ignored.
REQ-039 aluop=10 funct 000010, b=32'h8000_0000, shamt=31, reset asserted at SHIFT cycle 10 -> no done, busy=0, result=0, zero=1 next cycle.
REQ-040 aluop=11 -> done after 1 cycle, illegal=1, result=0; back-to-back start in DONE with aluop=10 funct 100111, a=b=0 -> next cycle result=32'hFFFF_FFFF, illegal=0.
